// File: rtl/ball_centroid_if.sv
`default_nettype none
// ============================================================================
// Module   : ball_centroid_if
// Desc     : Bundle between the HSV pixel source / SPI threshold registers and
//            the ball_centroid block. master = producer side, slave = centroid
//            block. Bounding-box result signals exist only when the macro
//            CENTROID_BBOX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ball_centroid_if #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int CW = 19
);
    // Camera timing and pixel stream
    logic          vsync;
    logic          href;
    logic          pix_valid;
    logic [8:0]    hue;
    logic          hue_invalid;
    logic [4:0]    saturation;
    logic [4:0]    value;
    // Classification thresholds
    logic [8:0]    hue_lo;
    logic [8:0]    hue_hi;
    logic [4:0]    sat_min;
    logic [4:0]    val_min;
    // Frame results
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [CW-1:0] count;
    logic          found;
    logic          result_valid;
    logic          overrun;
`ifdef CENTROID_BBOX_EN
    logic [XW-1:0] bb_xmin;
    logic [XW-1:0] bb_xmax;
    logic [YW-1:0] bb_ymin;
    logic [YW-1:0] bb_ymax;
`endif

    modport master (
        output vsync, href, pix_valid, hue, hue_invalid, saturation, value,
        output hue_lo, hue_hi, sat_min, val_min,
        input  cx, cy, count, found, result_valid, overrun
`ifdef CENTROID_BBOX_EN
        , input bb_xmin, bb_xmax, bb_ymin, bb_ymax
`endif
    );

    modport slave (
        input  vsync, href, pix_valid, hue, hue_invalid, saturation, value,
        input  hue_lo, hue_hi, sat_min, val_min,
        output cx, cy, count, found, result_valid, overrun
`ifdef CENTROID_BBOX_EN
        , output bb_xmin, bb_xmax, bb_ymin, bb_ymax
`endif
    );
endinterface
`default_nettype wire

// File: rtl/ball_centroid.sv
`default_nettype none
// ============================================================================
// Module   : ball_centroid
// Desc     : Classifies each HSV pixel against programmable hue/sat/value
//            thresholds, accumulates count and coordinate sums of matching
//            pixels over a camera frame and, at frame end, runs a sequential
//            restoring divider to produce the ball centroid (cx, cy).
//            Macro CENTROID_BBOX_EN adds a per-frame bounding box of matches.
// Revision : 1.0 - initial release
// ============================================================================
module ball_centroid #(
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int CW        = 19,
    parameter int SW        = 28,
    parameter int MIN_COUNT = 16
) (
    input  logic           clk,
    input  logic           res,
    ball_centroid_if.slave bus
);
    localparam int              c_BW        = $clog2(SW + 1);
    localparam logic [2:0]      c_ST_IDLE   = 3'd0;
    localparam logic [2:0]      c_ST_CHECK  = 3'd1;
    localparam logic [2:0]      c_ST_DIVX   = 3'd2;
    localparam logic [2:0]      c_ST_DIVY   = 3'd3;
    localparam logic [2:0]      c_ST_DONE   = 3'd4;
    localparam logic [CW-1:0]   c_MIN_CNT   = CW'(MIN_COUNT);
    localparam logic [c_BW-1:0] c_LAST_STEP = c_BW'(SW - 1);
    localparam logic [XW-1:0]   c_X_ONES    = {XW{1'b1}};
    localparam logic [YW-1:0]   c_Y_ONES    = {YW{1'b1}};
    localparam logic [CW-1:0]   c_C_ONES    = {CW{1'b1}};
    localparam logic [SW-1:0]   c_S_ONES    = {SW{1'b1}};

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic            r_vsync_d;
    logic            r_href_d;
    logic [XW-1:0]   r_x_cnt;
    logic [YW-1:0]   r_y_cnt;
    logic [CW-1:0]   r_acc_cnt;
    logic [SW-1:0]   r_acc_sx;
    logic [SW-1:0]   r_acc_sy;
    logic [CW-1:0]   r_div_cnt;
    logic [SW-1:0]   r_div_sx;
    logic [SW-1:0]   r_div_sy;
    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [CW-1:0]   r_rem;
    logic [SW-1:0]   r_quo;
    logic [c_BW-1:0] r_step;
    logic [XW-1:0]   r_qx;
    logic [YW-1:0]   r_qy;
    logic [XW-1:0]   r_cx;
    logic [YW-1:0]   r_cy;
    logic [CW-1:0]   r_count;
    logic            r_found;
    logic            r_result_valid;
    logic            r_overrun;

    logic            w_frame_end;
    logic            w_href_fall;
    logic            w_hue_ge_lo;
    logic            w_hue_le_hi;
    logic            w_in_window;
    logic            w_match;
    logic [CW-1:0]   w_cnt_inc;
    logic [SW:0]     w_sx_sum;
    logic [SW:0]     w_sy_sum;
    logic [SW-1:0]   w_sx_sat;
    logic [SW-1:0]   w_sy_sat;
    logic            w_below_min;
    logic            w_last_step;
    logic [CW:0]     w_shift;
    logic            w_ge;
    logic [CW-1:0]   w_sub;
    logic [CW-1:0]   w_rem_next;
    logic [SW-1:0]   w_quo_next;
    logic            w_capture;
    logic            w_div_start;
    logic            w_div_run;
    logic            w_publish;
    logic            w_overrun_set;

    // ------------------------------------------------------------------------
    // Edge detection and pixel classification
    // ------------------------------------------------------------------------
    assign w_frame_end = bus.vsync & ~r_vsync_d;
    assign w_href_fall = r_href_d & ~bus.href;

    // Inverted bounds (lo > hi) describe a window that wraps through hue 0.
    assign w_hue_ge_lo = (bus.hue >= bus.hue_lo);
    assign w_hue_le_hi = (bus.hue <= bus.hue_hi);
    assign w_in_window = (bus.hue_lo <= bus.hue_hi) ? (w_hue_ge_lo & w_hue_le_hi)
                                                    : (w_hue_ge_lo | w_hue_le_hi);
    assign w_match     = bus.pix_valid & ~bus.hue_invalid & w_in_window
                       & (bus.saturation >= bus.sat_min)
                       & (bus.value >= bus.val_min);

    // Saturating accumulator updates
    assign w_cnt_inc = (r_acc_cnt == c_C_ONES) ? r_acc_cnt : r_acc_cnt + 1'b1;
    assign w_sx_sum  = {1'b0, r_acc_sx} + {{(SW + 1 - XW){1'b0}}, r_x_cnt};
    assign w_sy_sum  = {1'b0, r_acc_sy} + {{(SW + 1 - YW){1'b0}}, r_y_cnt};
    assign w_sx_sat  = w_sx_sum[SW] ? c_S_ONES : w_sx_sum[SW-1:0];
    assign w_sy_sat  = w_sy_sum[SW] ? c_S_ONES : w_sy_sum[SW-1:0];

    // Registered copies of vsync/href for edge detection
    always_ff @(posedge clk) begin
        if (res) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync_d <= bus.vsync;
            r_href_d  <= bus.href;
        end
    end

    // Pixel coordinate counters: x per strobe, y per line, cleared in blanking
    always_ff @(posedge clk) begin
        if (res || bus.vsync) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (w_href_fall) begin
            r_x_cnt <= '0;
            if (r_y_cnt != c_Y_ONES) begin
                r_y_cnt <= r_y_cnt + 1'b1;
            end
        end else if (bus.pix_valid && (r_x_cnt != c_X_ONES)) begin
            r_x_cnt <= r_x_cnt + 1'b1;
        end
    end

    // Frame accumulators; a pixel coincident with frame end starts the new frame
    always_ff @(posedge clk) begin
        if (res) begin
            r_acc_cnt <= '0;
            r_acc_sx  <= '0;
            r_acc_sy  <= '0;
        end else if (w_frame_end) begin
            r_acc_cnt <= w_match ? {{(CW - 1){1'b0}}, 1'b1} : '0;
            r_acc_sx  <= w_match ? {{(SW - XW){1'b0}}, r_x_cnt} : '0;
            r_acc_sy  <= w_match ? {{(SW - YW){1'b0}}, r_y_cnt} : '0;
        end else if (w_match) begin
            r_acc_cnt <= w_cnt_inc;
            r_acc_sx  <= w_sx_sat;
            r_acc_sy  <= w_sy_sat;
        end
    end

    // Snapshot of the completed frame; frames ending mid-computation are dropped
    always_ff @(posedge clk) begin
        if (res) begin
            r_div_cnt <= '0;
            r_div_sx  <= '0;
            r_div_sy  <= '0;
        end else if (w_capture) begin
            r_div_cnt <= r_acc_cnt;
            r_div_sx  <= r_acc_sx;
            r_div_sy  <= r_acc_sy;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    assign w_below_min = (r_div_cnt < c_MIN_CNT);
    assign w_last_step = (r_step == c_LAST_STEP);

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_frame_end) w_state_next = c_ST_CHECK;
            c_ST_CHECK: w_state_next = w_below_min ? c_ST_DONE : c_ST_DIVX;
            c_ST_DIVX:  if (w_last_step) w_state_next = c_ST_DIVY;
            c_ST_DIVY:  if (w_last_step) w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_capture     = 1'b0;
        w_div_start   = 1'b0;
        w_div_run     = 1'b0;
        w_publish     = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            c_ST_IDLE:  w_capture   = w_frame_end;
            c_ST_CHECK: w_div_start = ~w_below_min;
            c_ST_DIVX:  w_div_run   = 1'b1;
            c_ST_DIVY:  w_div_run   = 1'b1;
            c_ST_DONE:  w_publish   = 1'b1;
            default:    w_publish   = 1'b0;
        endcase
        if (r_state != c_ST_IDLE) begin
            w_overrun_set = w_frame_end;
        end
    end

    // ------------------------------------------------------------------------
    // Restoring divider, shared by the x and y quotients
    // ------------------------------------------------------------------------
    // The partial remainder always stays below the divisor, so the shifted
    // value fits CW+1 bits and the difference fits CW bits.
    assign w_shift    = {r_rem, r_quo[SW-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div_cnt});
    assign w_sub      = w_shift[CW-1:0] - r_div_cnt;
    assign w_rem_next = w_ge ? w_sub : w_shift[CW-1:0];
    assign w_quo_next = {r_quo[SW-2:0], w_ge};

    // One quotient bit per clock; sum-y is loaded as sum-x finishes
    always_ff @(posedge clk) begin
        if (res) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_step <= '0;
            r_qx   <= '0;
            r_qy   <= '0;
        end else if (w_div_start) begin
            r_rem  <= '0;
            r_quo  <= r_div_sx;
            r_step <= '0;
        end else if (w_div_run) begin
            if (w_last_step) begin
                r_rem  <= '0;
                r_step <= '0;
                if (r_state == c_ST_DIVX) begin
                    r_qx  <= w_quo_next[XW-1:0];
                    r_quo <= r_div_sy;
                end else begin
                    r_qy  <= w_quo_next[YW-1:0];
                    r_quo <= w_quo_next;
                end
            end else begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_step <= r_step + 1'b1;
            end
        end
    end

    // Result registers; centroid held over frames where the ball is not found
    always_ff @(posedge clk) begin
        if (res) begin
            r_cx           <= '0;
            r_cy           <= '0;
            r_count        <= '0;
            r_found        <= 1'b0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_result_valid <= w_publish;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
            if (w_publish) begin
                r_count <= r_div_cnt;
                r_found <= ~w_below_min;
                if (!w_below_min) begin
                    r_cx <= r_qx;
                    r_cy <= r_qy;
                end
            end
        end
    end

    assign bus.cx           = r_cx;
    assign bus.cy           = r_cy;
    assign bus.count        = r_count;
    assign bus.found        = r_found;
    assign bus.result_valid = r_result_valid;
    assign bus.overrun      = r_overrun;

`ifdef CENTROID_BBOX_EN
    // ------------------------------------------------------------------------
    // Bounding box of matching pixels
    // ------------------------------------------------------------------------
    logic [XW-1:0] r_acc_xmin;
    logic [XW-1:0] r_acc_xmax;
    logic [YW-1:0] r_acc_ymin;
    logic [YW-1:0] r_acc_ymax;
    logic [XW-1:0] r_div_xmin;
    logic [XW-1:0] r_div_xmax;
    logic [YW-1:0] r_div_ymin;
    logic [YW-1:0] r_div_ymax;
    logic [XW-1:0] r_bb_xmin;
    logic [XW-1:0] r_bb_xmax;
    logic [YW-1:0] r_bb_ymin;
    logic [YW-1:0] r_bb_ymax;

    // Min/max trackers start empty (min all-ones, max zero) each frame
    always_ff @(posedge clk) begin
        if (res) begin
            r_acc_xmin <= c_X_ONES;
            r_acc_xmax <= '0;
            r_acc_ymin <= c_Y_ONES;
            r_acc_ymax <= '0;
        end else if (w_frame_end) begin
            r_acc_xmin <= w_match ? r_x_cnt : c_X_ONES;
            r_acc_xmax <= w_match ? r_x_cnt : '0;
            r_acc_ymin <= w_match ? r_y_cnt : c_Y_ONES;
            r_acc_ymax <= w_match ? r_y_cnt : '0;
        end else if (w_match) begin
            if (r_x_cnt < r_acc_xmin) r_acc_xmin <= r_x_cnt;
            if (r_x_cnt > r_acc_xmax) r_acc_xmax <= r_x_cnt;
            if (r_y_cnt < r_acc_ymin) r_acc_ymin <= r_y_cnt;
            if (r_y_cnt > r_acc_ymax) r_acc_ymax <= r_y_cnt;
        end
    end

    // Box snapshot taken alongside the count/sum snapshot
    always_ff @(posedge clk) begin
        if (res) begin
            r_div_xmin <= '0;
            r_div_xmax <= '0;
            r_div_ymin <= '0;
            r_div_ymax <= '0;
        end else if (w_capture) begin
            r_div_xmin <= r_acc_xmin;
            r_div_xmax <= r_acc_xmax;
            r_div_ymin <= r_acc_ymin;
            r_div_ymax <= r_acc_ymax;
        end
    end

    // Box outputs follow the centroid: updated only for found frames
    always_ff @(posedge clk) begin
        if (res) begin
            r_bb_xmin <= '0;
            r_bb_xmax <= '0;
            r_bb_ymin <= '0;
            r_bb_ymax <= '0;
        end else if (w_publish && !w_below_min) begin
            r_bb_xmin <= r_div_xmin;
            r_bb_xmax <= r_div_xmax;
            r_bb_ymin <= r_div_ymin;
            r_bb_ymax <= r_div_ymax;
        end
    end

    assign bus.bb_xmin = r_bb_xmin;
    assign bus.bb_xmax = r_bb_xmax;
    assign bus.bb_ymin = r_bb_ymin;
    assign bus.bb_ymax = r_bb_ymax;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ball_centroid.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_centroid
// Desc     : Self-checking bench for ball_centroid: classification table,
//            directed frames (empty, block, wrap window, below minimum,
//            overrun, reset mid-divide) and random frames against a
//            pixel-list reference model. Bounding box checked when
//            CENTROID_BBOX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_centroid;
    localparam int XW = 10, YW = 9, CW = 19, SW = 28, MINC = 16;
    localparam int LAT_FOUND = 2 * SW + 3;
    localparam int LAT_MISS  = 3;

    logic clk;
    logic res;
    int   n_chk = 0;
    int   n_err = 0;
    int   rv_pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ball_centroid_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

    ball_centroid #(.XW(XW), .YW(YW), .CW(CW), .SW(SW), .MIN_COUNT(MINC)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always @(negedge clk) if (bus.result_valid === 1'b1) rv_pulses <= rv_pulses + 1;

    // Frame image: attributes per (line, pixel)
    int fh [64][128];
    int fs [64][128];
    int fv [64][128];
    int fi [64][128];

    int th_lo, th_hi, th_smin, th_vmin;
    int m_cx = 0, m_cy = 0, m_count = 0, m_found = 0;
    int m_bx0 = 0, m_bx1 = 0, m_by0 = 0, m_by1 = 0;

    typedef struct {
        int lo, hi, smin, vmin;
        int h, s, v, inv;
        int exp;
    } vec_t;
    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_thr(input int lo, input int hi, input int smin, input int vmin);
        th_lo = lo; th_hi = hi; th_smin = smin; th_vmin = vmin;
        bus.hue_lo  = 9'(lo);
        bus.hue_hi  = 9'(hi);
        bus.sat_min = 5'(smin);
        bus.val_min = 5'(vmin);
    endtask

    function automatic bit ref_match(input int h, input int s, input int v, input int inv);
        if (inv != 0) return 1'b0;
        if (s < th_smin || v < th_vmin) return 1'b0;
        if (th_lo <= th_hi) return (h >= th_lo && h <= th_hi);
        return (h >= th_lo || h <= th_hi);
    endfunction

    task automatic fill(input int nl, input int np, input int h, input int s, input int v);
        for (int y = 0; y < nl; y++)
            for (int x = 0; x < np; x++) begin
                fh[y][x] = h; fs[y][x] = s; fv[y][x] = v; fi[y][x] = 0;
            end
    endtask

    // Reference: scan the image, average coordinates of matching pixels
    task automatic model_frame(input int nl, input int np);
        int cnt, sx, sy, x0, x1, y0, y1;
        cnt = 0; sx = 0; sy = 0; x0 = 1 << XW; x1 = -1; y0 = 1 << YW; y1 = -1;
        for (int y = 0; y < nl; y++)
            for (int x = 0; x < np; x++)
                if (ref_match(fh[y][x], fs[y][x], fv[y][x], fi[y][x])) begin
                    cnt++; sx += x; sy += y;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
        m_count = cnt;
        m_found = (cnt >= MINC) ? 1 : 0;
        if (m_found != 0) begin
            m_cx = sx / cnt; m_cy = sy / cnt;
            m_bx0 = x0; m_bx1 = x1; m_by0 = y0; m_by1 = y1;
        end
    endtask

    task automatic drive_line(input int y, input int np, input bit gaps);
        bus.href = 1'b1;
        tick();
        for (int x = 0; x < np; x++) begin
            bus.hue         = 9'(fh[y][x]);
            bus.saturation  = 5'(fs[y][x]);
            bus.value       = 5'(fv[y][x]);
            bus.hue_invalid = fi[y][x][0];
            bus.pix_valid   = 1'b1;
            tick();
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.pix_valid = 1'b0;
                tick();
            end
        end
        bus.pix_valid = 1'b0;
        bus.href      = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_frame(input int nl, input int np, input bit gaps);
        bus.vsync = 1'b0;
        tick();
        tick();
        for (int y = 0; y < nl; y++) drive_line(y, np, gaps);
    endtask

    // Raise vsync and measure clocks until result_valid; verify pulse width
    task automatic end_frame(input int exp_found, input string tag);
        int lat;
        lat = 0;
        bus.vsync = 1'b1;
        for (int n = 1; n <= LAT_FOUND + 10 && lat == 0; n++) begin
            tick();
            if (bus.result_valid === 1'b1) lat = n;
        end
        chk({tag, " latency"}, lat, (exp_found != 0) ? LAT_FOUND : LAT_MISS);
    endtask

    task automatic check_pulse_end(input string tag);
        tick();
        chk({tag, " result_valid one-cycle"}, int'(bus.result_valid), 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, int'(bus.count), m_count);
        chk({tag, " found"}, int'(bus.found), m_found);
        chk({tag, " cx"}, int'(bus.cx), m_cx);
        chk({tag, " cy"}, int'(bus.cy), m_cy);
`ifdef CENTROID_BBOX_EN
        chk({tag, " bb_xmin"}, int'(bus.bb_xmin), m_bx0);
        chk({tag, " bb_xmax"}, int'(bus.bb_xmax), m_bx1);
        chk({tag, " bb_ymin"}, int'(bus.bb_ymin), m_by0);
        chk({tag, " bb_ymax"}, int'(bus.bb_ymax), m_by1);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " cx"}, int'(bus.cx), 0);
        chk({tag, " cy"}, int'(bus.cy), 0);
        chk({tag, " count"}, int'(bus.count), 0);
        chk({tag, " found"}, int'(bus.found), 0);
        chk({tag, " result_valid"}, int'(bus.result_valid), 0);
        chk({tag, " overrun"}, int'(bus.overrun), 0);
    endtask

    initial begin
        int nl, np, rv0;
        tbl[0]  = '{0, 20, 4, 4, 10, 10, 10, 0, 1};
        tbl[1]  = '{0, 20, 4, 4, 20, 10, 10, 0, 1};
        tbl[2]  = '{0, 20, 4, 4, 21, 10, 10, 0, 0};
        tbl[3]  = '{5, 20, 4, 4, 5, 10, 10, 0, 1};
        tbl[4]  = '{5, 20, 4, 4, 4, 10, 10, 0, 0};
        tbl[5]  = '{0, 20, 4, 4, 10, 10, 10, 1, 0};
        tbl[6]  = '{0, 20, 4, 4, 10, 4, 4, 0, 1};
        tbl[7]  = '{0, 20, 4, 4, 10, 3, 10, 0, 0};
        tbl[8]  = '{0, 20, 4, 4, 10, 10, 3, 0, 0};
        tbl[9]  = '{340, 20, 4, 4, 350, 10, 10, 0, 1};
        tbl[10] = '{340, 20, 4, 4, 10, 10, 10, 0, 1};
        tbl[11] = '{340, 20, 4, 4, 180, 10, 10, 0, 0};
        tbl[12] = '{340, 20, 4, 4, 339, 10, 10, 0, 0};
        tbl[13] = '{340, 20, 4, 4, 21, 10, 10, 0, 0};
        tbl[14] = '{100, 100, 0, 0, 100, 0, 0, 0, 1};
        tbl[15] = '{100, 100, 0, 0, 101, 31, 31, 0, 0};

        res = 1'b1;
        bus.vsync = 1'b0; bus.href = 1'b0; bus.pix_valid = 1'b0;
        bus.hue = '0; bus.hue_invalid = 1'b0; bus.saturation = '0; bus.value = '0;
        set_thr(0, 20, 4, 4);
        tick(); tick(); tick();
        res = 1'b0;
        tick();
        check_zero("reset");

        // Empty frame: nothing matches
        fill(4, 8, 180, 20, 20);
        model_frame(4, 8);
        drive_frame(4, 8, 1'b0);
        end_frame(0, "empty");
        chk("empty count", int'(bus.count), 0);
        chk("empty found", int'(bus.found), 0);
        chk("empty cx", int'(bus.cx), 0);
        chk("empty cy", int'(bus.cy), 0);
        check_pulse_end("empty");

        // 4x4 block at x=100..103, y=50..53
        fill(54, 104, 180, 20, 20);
        for (int y = 50; y < 54; y++)
            for (int x = 100; x < 104; x++) fh[y][x] = 10;
        model_frame(54, 104);
        drive_frame(54, 104, 1'b0);
        end_frame(1, "block");
        chk("block count", int'(bus.count), 16);
        chk("block found", int'(bus.found), 1);
        chk("block cx", int'(bus.cx), 101);
        chk("block cy", int'(bus.cy), 51);
`ifdef CENTROID_BBOX_EN
        chk("block bb_xmin", int'(bus.bb_xmin), 100);
        chk("block bb_xmax", int'(bus.bb_xmax), 103);
        chk("block bb_ymin", int'(bus.bb_ymin), 50);
        chk("block bb_ymax", int'(bus.bb_ymax), 53);
`endif
        check_pulse_end("block");

        // One short of the minimum: centroid holds the previous frame
        fill(1, 20, 180, 20, 20);
        for (int x = 0; x < 15; x++) fh[0][x] = 5;
        model_frame(1, 20);
        drive_frame(1, 20, 1'b1);
        end_frame(0, "min-1");
        chk("min-1 count", int'(bus.count), 15);
        chk("min-1 found", int'(bus.found), 0);
        chk("min-1 cx held", int'(bus.cx), 101);
        chk("min-1 cy held", int'(bus.cy), 51);
        check_model("min-1");

        // Classification table: 16 identical pixels on line 0
        foreach (tbl[i]) begin
            set_thr(tbl[i].lo, tbl[i].hi, tbl[i].smin, tbl[i].vmin);
            fill(1, 16, tbl[i].h, tbl[i].s, tbl[i].v);
            for (int x = 0; x < 16; x++) fi[0][x] = tbl[i].inv;
            model_frame(1, 16);
            drive_frame(1, 16, 1'b0);
            end_frame(tbl[i].exp, $sformatf("tbl[%0d]", i));
            chk($sformatf("tbl[%0d] found", i), int'(bus.found), tbl[i].exp);
            chk($sformatf("tbl[%0d] count", i), int'(bus.count), tbl[i].exp != 0 ? 16 : 0);
            if (tbl[i].exp != 0) chk($sformatf("tbl[%0d] cx", i), int'(bus.cx), 7);
        end

        // Wrapping window: 350/10 match, 180 does not
        set_thr(340, 20, 4, 4);
        fill(1, 30, 180, 20, 20);
        for (int x = 0; x < 30; x++) fh[0][x] = (x % 3 == 0) ? 350 : ((x % 3 == 1) ? 10 : 180);
        model_frame(1, 30);
        drive_frame(1, 30, 1'b1);
        end_frame(1, "wrap");
        chk("wrap count", int'(bus.count), 20);
        chk("wrap cx", int'(bus.cx), 14);
        check_model("wrap");

        // Overrun: second frame end while dividing
        set_thr(0, 20, 4, 4);
        fill(1, 16, 10, 20, 20);
        model_frame(1, 16);
        drive_frame(1, 16, 1'b0);
        bus.vsync = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        bus.vsync = 1'b0;
        drive_line(0, 3, 1'b0);
        rv0 = rv_pulses;
        bus.vsync = 1'b1;
        begin
            int lat;
            lat = 0;
            for (int n = 12; n <= LAT_FOUND + 10 && lat == 0; n++) begin
                tick();
                if (bus.result_valid === 1'b1) lat = n;
            end
            chk("overrun first latency", lat, LAT_FOUND);
        end
        check_model("overrun first");
        chk("overrun flag", int'(bus.overrun), 1);
        for (int n = 0; n < LAT_FOUND + 10; n++) tick();
        chk("overrun dropped result", rv_pulses - rv0, 1);
        fill(2, 20, 180, 20, 20);
        for (int x = 2; x < 20; x++) fh[1][x] = 15;
        model_frame(2, 20);
        drive_frame(2, 20, 1'b0);
        end_frame(1, "after-overrun");
        check_model("after-overrun");
        chk("overrun sticky", int'(bus.overrun), 1);

        // Random frames against the reference model
        for (int f = 0; f < 12; f++) begin
            set_thr($urandom_range(0, 359), $urandom_range(0, 359),
                    $urandom_range(0, 12), $urandom_range(0, 12));
            nl = $urandom_range(1, 5);
            np = $urandom_range(4, 24);
            for (int y = 0; y < nl; y++)
                for (int x = 0; x < np; x++) begin
                    fh[y][x] = (($urandom_range(0, 1) == 0) ? th_lo : $urandom_range(0, 359));
                    fs[y][x] = $urandom_range(0, 31);
                    fv[y][x] = $urandom_range(0, 31);
                    fi[y][x] = ($urandom_range(0, 7) == 0) ? 1 : 0;
                end
            model_frame(nl, np);
            drive_frame(nl, np, 1'b1);
            end_frame(m_found, $sformatf("rand%0d", f));
            check_model($sformatf("rand%0d", f));
        end

        // Reset in the middle of a division aborts it
        set_thr(0, 20, 4, 4);
        fill(1, 16, 10, 20, 20);
        drive_frame(1, 16, 1'b0);
        bus.vsync = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        res = 1'b1;
        bus.vsync = 1'b0;
        tick();
        res = 1'b0;
        check_zero("midreset");
        m_cx = 0; m_cy = 0; m_count = 0; m_found = 0;
        m_bx0 = 0; m_bx1 = 0; m_by0 = 0; m_by1 = 0;
        rv0 = rv_pulses;
        for (int n = 0; n < LAT_FOUND + 10; n++) tick();
        chk("midreset no result", rv_pulses - rv0, 0);

        // Recovery after reset
        fill(2, 12, 180, 20, 20);
        for (int x = 0; x < 12; x++) begin fh[0][x] = 3; fh[1][x] = 17; end
        model_frame(2, 12);
        drive_frame(2, 12, 1'b1);
        end_frame(1, "recover");
        check_model("recover");
        chk("recover overrun", int'(bus.overrun), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
